conv_window_loader: RTL



---
 rtl/conv_window_loader_pkg.sv | 26 ++
 rtl/conv_window_loader_if.sv | 25 ++
 rtl/conv_window_loader_shreg.sv | 21 ++
 rtl/conv_window_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/conv_window_loader_pkg.sv
// conv_pkg: shared widths, state encoding and nibble shift helper for conv_window_loader
package conv_pkg;

    localparam int DW   = 4;
    localparam int TAPS = 9;
    localparam int VW   = DW * TAPS;
    localparam int PW   = 72;
    localparam int PAD  = PW - VW;

    // Element k of a packed vector occupies [VW-1-DW*k -: DW]; element 0 is the oldest.
    localparam int ELEM_LAST_HI = DW - 1;

    localparam logic [3:0] CNT_FULL = 4'd9;

    typedef enum logic [1:0] {
        S_COEF,
        S_FILL,
        S_STREAM
    } state_t;

    // New nibble enters at the last element; everything else moves one slot toward element 0.
    function automatic logic [VW-1:0] shift_in(input logic [VW-1:0] v, input logic [DW-1:0] d);
        return {v[VW-DW-1:0], d};
    endfunction

endpackage

// File: rtl/conv_window_loader_if.sv
// conv_window_loader_if: input beat stream and output window bundle for conv_window_loader
interface conv_window_loader_if;
    import conv_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic              s_coef;
    logic [DW-1:0]     s_data;
    logic              m_valid;
    logic              m_ready;
    logic [PW-1:0]     m_a;
    logic [PW-1:0]     m_b;
    logic              o_drop;

    modport slave (
        input  s_valid, s_coef, s_data, m_ready,
        output s_ready, m_valid, m_a, m_b, o_drop
    );

    modport master (
        output s_valid, s_coef, s_data, m_ready,
        input  s_ready, m_valid, m_a, m_b, o_drop
    );

endinterface

// File: rtl/conv_window_loader_shreg.sv
// conv_nibble_shreg: 9 x 4-bit shift register with shift enable and synchronous clear
module conv_nibble_shreg
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [VW-1:0] q
);

    // clear wins over shift so a clear and shift in the same cycle leaves the register empty
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (en)
            q <= shift_in(q, din);
    end

endmodule

// File: rtl/conv_window_loader.sv
// conv_window_loader: serial 4-bit beats -> 9-sample window + 9 coefficients for the convolver
// Optional: CONV_LOADER_ZEROPAD_EN emits windows from the first sample after coefficient load.
module conv_window_loader
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    conv_window_loader_if.slave  bus
);

    state_t        state, state_nx;
    logic [3:0]    coef_cnt, coef_cnt_nx;
    logic [3:0]    fill_cnt, fill_cnt_nx;
    logic [VW-1:0] win, coefs;
    logic          s_ready, accept, coef_acc, samp_acc;
    logic          win_clr, win_en, coef_en, emit, drop_nx;
    logic          m_valid, o_drop;
    logic [VW-1:0] m_a, m_b;

    assign s_ready  = !m_valid || bus.m_ready;
    assign accept   = bus.s_valid && s_ready;
    assign coef_acc = accept && bus.s_coef;
    assign samp_acc = accept && !bus.s_coef;

    conv_nibble_shreg u_win (
        .clk (clk),
        .rst (rst),
        .clr (win_clr),
        .en  (win_en),
        .din (bus.s_data),
        .q   (win)
    );

    conv_nibble_shreg u_coef (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (coef_en),
        .din (bus.s_data),
        .q   (coefs)
    );

    // state and fill/coefficient counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_COEF;
            coef_cnt <= '0;
            fill_cnt <= '0;
        end else begin
            state    <= state_nx;
            coef_cnt <= coef_cnt_nx;
            fill_cnt <= fill_cnt_nx;
        end
    end

    // beat decode: coefficient beats restart the window, samples fill it or are dropped
    always_comb begin
        state_nx    = state;
        coef_cnt_nx = coef_cnt;
        fill_cnt_nx = fill_cnt;
        win_clr     = 1'b0;
        win_en      = 1'b0;
        coef_en     = 1'b0;
        emit        = 1'b0;
        drop_nx     = 1'b0;
        if (coef_acc) begin
            coef_en     = 1'b1;
            win_clr     = 1'b1;
            fill_cnt_nx = '0;
            coef_cnt_nx = (coef_cnt == CNT_FULL) ? 4'd1 : coef_cnt + 4'd1;
            state_nx    = (coef_cnt_nx == CNT_FULL) ? S_FILL : S_COEF;
        end else if (samp_acc) begin
            if (state == S_COEF) begin
                drop_nx = 1'b1;
            end else begin
                win_en      = 1'b1;
                fill_cnt_nx = (fill_cnt == CNT_FULL) ? fill_cnt : fill_cnt + 4'd1;
                state_nx    = (fill_cnt_nx == CNT_FULL) ? S_STREAM : S_FILL;
`ifdef CONV_LOADER_ZEROPAD_EN
                emit        = 1'b1;
`else
                emit        = (fill_cnt_nx == CNT_FULL);
`endif
            end
        end
    end

    // registered output stage: load on emit, otherwise hold until the convolver takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= drop_nx;
            if (emit) begin
                m_valid <= 1'b1;
                m_a     <= shift_in(win, bus.s_data);
                m_b     <= coefs;
            end else if (bus.m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_a     = {{PAD{1'b0}}, m_a};
    assign bus.m_b     = {{PAD{1'b0}}, m_b};
    assign bus.o_drop  = o_drop;

endmodule
